adc_multi_avg_scale: RTL and testbench
======================================

Name: adc_multi_avg_scale

Overview:
Shared averaging and scaling engine for N ADC channels (XADC, PWM ramp, R2R SAR, and future channels). It replaces one per-ADC processing instance with a single time-shared pipeline fed by a round-robin arbiter. Each channel has its own pending register, accumulator, sample counter and output registers. Sits between the ADC front ends and the menu/display subsystem.

Parameters:
N_CH, 3, number of input channels (1..8)
DATA_W, 16, raw sample width per channel
IN_SHIFT, 4, right-shift applied to raw sample before processing
AVG_LOG2, 8, log2 of block-average length (1..10)
SCALING_FACTOR, 310866, unsigned multiplier constant (<2^32)
SHIFT_FACTOR, 19, right-shift after multiply

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
sample_valid  in  N_CH  one-cycle pulse per channel; sample present
sample_data  in  N_CH*DATA_W  channel c occupies [c*DATA_W +: DATA_W]
avg_sel  in  1  1 = block average of 2^AVG_LOG2 samples, 0 = pass-through
clear  in  1  synchronous flush
ave_data  out  N_CH*16  per-channel averaged (unscaled) result
scaled_data  out  N_CH*16  per-channel scaled result
out_valid  out  N_CH  one-cycle pulse when that channel's outputs update
overrun  out  N_CH  sticky; a sample was dropped

Behaviour:
- Reset (reset=0, async): all pending, accumulators, counters, pipeline valids, ave_data, scaled_data, out_valid and overrun go to 0. Arbiter priority pointer goes to ch0.
- Capture: at a rising edge with sample_valid[c]=1, pending[c] is set and the data is latched.
- Overrun:
  - If pending[c] is already set and c is not granted in that cycle, the new sample is dropped and overrun[c] is set.
  - If c is granted in the same cycle, the new sample is accepted and nothing is dropped.
- Arbiter: each cycle, grants the first set pending bit at or after the pointer. At most one grant per cycle. After a grant, the pointer moves to grant+1 (mod N_CH).
- Pipeline (shared, one grant per cycle, full throughput):
  - E1 (grant edge): x = data >> IN_SHIFT. avg_sel is sampled here.
    - avg_sel=1: acc[c] += x, cnt[c]++. When cnt wraps (2^AVG_LOG2 samples), stage-1 result = (acc + x) >> AVG_LOG2, then acc and cnt reset to 0.
    - avg_sel=0: stage-1 result = x, and acc[c]/cnt[c] are forced to 0.
    - Switching avg_sel 0->1 therefore starts a fresh block.
  - E2: prod = result * SCALING_FACTOR, DATA_W+32 bits wide, registered together with the channel tag.
  - E3: ave_data[c] <= result (zero-extended or truncated to 16 bits). scaled_data[c] <= prod >> SHIFT_FACTOR, saturated to 0xFFFF. out_valid[c] pulses for 1 cycle.
- Latency:
  - Uncontended: sample_valid at edge E0 gives out_valid high in the cycle after E3 (the 4th clock after E0).
  - Contention adds up to N_CH-1 cycles.
- Accumulator width: DATA_W-IN_SHIFT+AVG_LOG2 bits; it never overflows.
- Outputs hold their values between updates.
- clear=1 at an edge:
  - zeroes pending, acc, cnt, overrun and all in-flight pipeline valids; out_valid=0.
  - ave_data and scaled_data keep their values.
  - A sample_valid in the same cycle is dropped and does not set overrun.
- Reset mid-block: the partial block is discarded. After release, a full 2^AVG_LOG2 samples are needed before the next out_valid.

Decomposition:
- Package adc_proc_pkg:
  - MAX_CH=8
  - OUT_W=16
  - typedef of the pipeline stage struct {valid, chan index, result, prod}
  - saturate function
- Sub-module rr_arbiter (parameter N), holding the pending-vector to one-hot grant logic and the pointer register.

Test Plan:
1. avg_sel=1, ch0 gets 256 samples of 0x1000 -> exactly one out_valid[0] after the 256th sample. ave_data[0]=0x0100. scaled_data[0]=151 (0x0097). No other channel pulses.
2. avg_sel=1, ch1 gets 256 samples of 0xFFF0 -> ave_data[1]=4095 (0x0FFF), scaled_data[1]=2428 (0x097C).
3. avg_sel=0, a single ch2 sample 0x8000 at E0 -> out_valid[2] high in the cycle after E3 (the 4th clock after E0). ave_data[2]=0x0800, scaled_data[2]=1214.
4. avg_sel=0, all 3 channels valid in the same cycle after reset -> out_valid on ch0, ch1, ch2 in 3 consecutive cycles. overrun stays 0.
5. Same as 4, plus ch2 valid again on the next cycle -> overrun[2]=1. Only the first ch2 sample is emitted. clear then returns overrun to 0.
6. avg_sel=1, assert reset low after 100 samples on ch0, then release -> all outputs read 0. The next out_valid[0] comes only after 256 further samples.

Source files
------------

// File: rtl/adc_proc_pkg.sv
// Shared types and helpers for the multi-channel ADC averaging/scaling engine.
//   MAX_CH  : largest supported channel count; sets the channel tag width
//   OUT_W   : width of the per-channel ave_data / scaled_data results
//   stage_t : pipeline stage record {valid, chan, result, prod}
//   saturate: clamps a wide unsigned value to OUT_W bits
package adc_proc_pkg;

    localparam int unsigned MAX_CH = 8;
    localparam int unsigned OUT_W  = 16;
    localparam int unsigned CH_W   = $clog2(MAX_CH);
    // Stage results are carried at output width; the product adds the 32-bit multiplier.
    localparam int unsigned RES_W  = OUT_W;
    localparam int unsigned PROD_W = RES_W + 32;

    typedef struct packed {
        logic              valid;
        logic [CH_W-1:0]   chan;
        logic [RES_W-1:0]  result;
        logic [PROD_W-1:0] prod;
    } stage_t;

    function automatic logic [OUT_W-1:0] saturate(input logic [PROD_W-1:0] v);
        if (|v[PROD_W-1:OUT_W]) begin
            return '1;
        end
        return v[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first set request at or after the priority pointer.
//   clk, reset  : clock, asynchronous active-low reset (pointer returns to 0)
//   req         : request vector, one bit per channel
//   grant       : one-hot grant (all zero when nothing requests)
//   grant_valid : a grant was issued this cycle
//   grant_idx   : binary index of the granted channel
module rr_arbiter
    import adc_proc_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [CH_W-1:0] grant_idx
);

    logic [CH_W-1:0] ptr_q, ptr_d;
    logic            found_hi, found_lo;
    logic [CH_W-1:0] idx_hi, idx_lo;

    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        // Two passes: requests at/after the pointer win over those that wrap around.
        for (int j = 0; j < int'(N); j++) begin
            if (!found_hi && req[j] && (CH_W'(j) >= ptr_q)) begin
                found_hi = 1'b1;
                idx_hi   = CH_W'(j);
            end
            if (!found_lo && req[j]) begin
                found_lo = 1'b1;
                idx_lo   = CH_W'(j);
            end
        end
        grant_valid = found_hi | found_lo;
        grant_idx   = found_hi ? idx_hi : idx_lo;
        grant       = '0;
        for (int j = 0; j < int'(N); j++) begin
            grant[j] = grant_valid && (grant_idx == CH_W'(j));
        end
        ptr_d = ptr_q;
        if (grant_valid) begin
            ptr_d = (grant_idx == CH_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/adc_multi_avg_scale.sv
// Time-shared averaging and scaling engine for N_CH ADC channels.
// Each channel captures samples into a pending register; a round-robin arbiter
// feeds one channel per cycle into a shared 3-stage pipeline
// (shift/accumulate -> multiply -> shift/saturate/output).
//   clk          : system clock
//   reset        : asynchronous active-low reset
//   sample_valid : per-channel one-cycle sample strobe
//   sample_data  : packed raw samples, channel c at [c*DATA_W +: DATA_W]
//   avg_sel      : 1 = block average of 2^AVG_LOG2 samples, 0 = pass-through
//   clear        : synchronous flush of pending, accumulators, pipeline and overrun
//   ave_data     : packed per-channel averaged (unscaled) results, 16 bits each
//   scaled_data  : packed per-channel scaled, saturated results, 16 bits each
//   out_valid    : per-channel one-cycle pulse when that channel's outputs update
//   overrun      : per-channel sticky flag, a sample was dropped
module adc_multi_avg_scale
    import adc_proc_pkg::*;
#(
    parameter int unsigned N_CH           = 3,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned IN_SHIFT       = 4,
    parameter int unsigned AVG_LOG2       = 8,
    parameter int unsigned SCALING_FACTOR = 310866,
    parameter int unsigned SHIFT_FACTOR   = 19
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          sample_valid,
    input  logic [N_CH*DATA_W-1:0]   sample_data,
    input  logic                     avg_sel,
    input  logic                     clear,
    output logic [N_CH*OUT_W-1:0]    ave_data,
    output logic [N_CH*OUT_W-1:0]    scaled_data,
    output logic [N_CH-1:0]          out_valid,
    output logic [N_CH-1:0]          overrun
);

    localparam int unsigned X_W   = DATA_W - IN_SHIFT;
    // A full block of maximum-valued samples fits without overflow.
    localparam int unsigned ACC_W = X_W + AVG_LOG2;
    localparam int unsigned CNT_W = AVG_LOG2;

    // Per-channel state
    logic [N_CH-1:0]   pending_q;
    logic [N_CH-1:0]   overrun_q;
    logic [DATA_W-1:0] data_q   [N_CH];
    logic [ACC_W-1:0]  acc_q    [N_CH];
    logic [CNT_W-1:0]  cnt_q    [N_CH];
    logic [OUT_W-1:0]  ave_q    [N_CH];
    logic [OUT_W-1:0]  scaled_q [N_CH];
    logic [N_CH-1:0]   out_valid_q;

    // Pipeline registers
    logic              s1_valid_q;
    logic [CH_W-1:0]   s1_chan_q;
    logic [RES_W-1:0]  s1_result_q;
    stage_t            s2_q;

    // Arbitration
    logic [N_CH-1:0]   req;
    logic [N_CH-1:0]   grant;
    logic              grant_valid;
    logic [CH_W-1:0]   grant_idx;

    // Capture control
    logic [N_CH-1:0]   accept;
    logic [N_CH-1:0]   drop;

    // Stage-1 datapath
    logic [DATA_W-1:0] data_sel;
    logic [ACC_W-1:0]  acc_sel;
    logic [CNT_W-1:0]  cnt_sel;
    logic [X_W-1:0]    x;
    logic [ACC_W-1:0]  acc_sum;
    logic              block_done;
    logic              s1_valid_d;
    logic [RES_W-1:0]  s1_result_d;

    // Nothing is granted during a flush, so no sample enters the pipeline.
    assign req = pending_q & {N_CH{~clear}};

    rr_arbiter #(
        .N (N_CH)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // A sample is accepted if its slot is free or is being drained this very cycle.
    assign accept = sample_valid & {N_CH{~clear}} & (~pending_q | grant);
    assign drop   = sample_valid & {N_CH{~clear}} & pending_q & ~grant;

    always_comb begin
        data_sel = '0;
        acc_sel  = '0;
        cnt_sel  = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            if (grant[c]) begin
                data_sel = data_q[c];
                acc_sel  = acc_q[c];
                cnt_sel  = cnt_q[c];
            end
        end
        x           = X_W'(data_sel >> IN_SHIFT);
        acc_sum     = acc_sel + ACC_W'(x);
        block_done  = (cnt_sel == '1);
        s1_valid_d  = grant_valid & (~avg_sel | block_done);
        s1_result_d = avg_sel ? RES_W'(acc_sum >> AVG_LOG2) : RES_W'(x);
    end

    // Capture, overrun and accumulator state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            overrun_q <= '0;
            for (int c = 0; c < int'(N_CH); c++) begin
                data_q[c] <= '0;
                acc_q[c]  <= '0;
                cnt_q[c]  <= '0;
            end
        end else if (clear) begin
            pending_q <= '0;
            overrun_q <= '0;
            for (int c = 0; c < int'(N_CH); c++) begin
                acc_q[c] <= '0;
                cnt_q[c] <= '0;
            end
        end else begin
            pending_q <= (pending_q & ~grant) | accept;
            overrun_q <= overrun_q | drop;
            for (int c = 0; c < int'(N_CH); c++) begin
                if (accept[c]) begin
                    data_q[c] <= sample_data[c*DATA_W +: DATA_W];
                end
                if (grant[c]) begin
                    // Pass-through or a completed block leaves the channel ready for a fresh block.
                    if (avg_sel && !block_done) begin
                        acc_q[c] <= acc_sum;
                        cnt_q[c] <= cnt_sel + 1'b1;
                    end else begin
                        acc_q[c] <= '0;
                        cnt_q[c] <= '0;
                    end
                end
            end
        end
    end

    // Shared pipeline: E1 result, E2 product, E3 per-channel outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_chan_q   <= '0;
            s1_result_q <= '0;
            s2_q        <= '0;
            out_valid_q <= '0;
            for (int c = 0; c < int'(N_CH); c++) begin
                ave_q[c]    <= '0;
                scaled_q[c] <= '0;
            end
        end else begin
            s1_valid_q  <= s1_valid_d & ~clear;
            s1_chan_q   <= grant_idx;
            s1_result_q <= s1_result_d;

            s2_q.valid  <= s1_valid_q & ~clear;
            s2_q.chan   <= s1_chan_q;
            s2_q.result <= s1_result_q;
            s2_q.prod   <= PROD_W'(s1_result_q) * PROD_W'(SCALING_FACTOR);

            for (int c = 0; c < int'(N_CH); c++) begin
                out_valid_q[c] <= s2_q.valid && !clear && (s2_q.chan == CH_W'(c));
                if (s2_q.valid && !clear && (s2_q.chan == CH_W'(c))) begin
                    ave_q[c]    <= s2_q.result;
                    scaled_q[c] <= saturate(s2_q.prod >> SHIFT_FACTOR);
                end
            end
        end
    end

    always_comb begin
        ave_data    = '0;
        scaled_data = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            ave_data[c*OUT_W +: OUT_W]    = ave_q[c];
            scaled_data[c*OUT_W +: OUT_W] = scaled_q[c];
        end
    end

    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_adc_multi_avg_scale.sv
// Directed self-checking bench for adc_multi_avg_scale (default parameters, 3 channels).
module tb_adc_multi_avg_scale;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  sample_valid;
    logic [47:0] sample_data;
    logic        avg_sel;
    logic        clear;
    logic [47:0] ave_data;
    logic [47:0] scaled_data;
    logic [2:0]  out_valid;
    logic [2:0]  overrun;

    int checks = 0;
    int errors = 0;
    int ov_count [3];

    always #5 clk = ~clk;

    adc_multi_avg_scale dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .avg_sel      (avg_sel),
        .clear        (clear),
        .ave_data     (ave_data),
        .scaled_data  (scaled_data),
        .out_valid    (out_valid),
        .overrun      (overrun)
    );

    // Advance one clock, land 1 ns after the edge, and tally output pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            if (out_valid[c]) ov_count[c]++;
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr_counts();
        for (int c = 0; c < 3; c++) ov_count[c] = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ave(input int c);
        return 32'(ave_data[c*16 +: 16]);
    endfunction

    function automatic logic [31:0] scl(input int c);
        return 32'(scaled_data[c*16 +: 16]);
    endfunction

    task automatic set_sample(input int ch, input logic [15:0] val);
        sample_valid[ch]          = 1'b1;
        sample_data[ch*16 +: 16]  = val;
    endtask

    // n back-to-back samples on one channel, one per clock
    task automatic burst(input int ch, input logic [15:0] val, input int n);
        for (int i = 0; i < n; i++) begin
            sample_valid = '0;
            set_sample(ch, val);
            tick();
        end
        sample_valid = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drain(2);
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset        = 1'b0;
        sample_valid = '0;
        sample_data  = '0;
        avg_sel      = 1'b0;
        clear        = 1'b0;
        clr_counts();
        drain(2);

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("rst_ave%0d", c), ave(c), 32'h0);
            chk($sformatf("rst_scaled%0d", c), scl(c), 32'h0);
        end
        reset = 1'b1;
        tick();

        // Block average on ch0: 255 samples give nothing, the 256th completes the block
        avg_sel = 1'b1;
        clr_counts();
        burst(0, 16'h1000, 255);
        drain(6);
        chk("t1_no_early_pulse", 32'(ov_count[0]), 32'd0);
        burst(0, 16'h1000, 1);
        drain(6);
        chk("t1_ch0_pulses", 32'(ov_count[0]), 32'd1);
        chk("t1_ch1_pulses", 32'(ov_count[1]), 32'd0);
        chk("t1_ch2_pulses", 32'(ov_count[2]), 32'd0);
        chk("t1_ave0", ave(0), 32'h0100);
        chk("t1_scaled0", scl(0), 32'd151);

        // Block average on ch1 with near full-scale input
        clr_counts();
        burst(1, 16'hFFF0, 256);
        drain(6);
        chk("t2_ch1_pulses", 32'(ov_count[1]), 32'd1);
        chk("t2_ch0_pulses", 32'(ov_count[0]), 32'd0);
        chk("t2_ave1", ave(1), 32'h0FFF);
        chk("t2_scaled1", scl(1), 32'd2428);
        chk("t2_ave0_held", ave(0), 32'h0100);

        // Reset mid-block discards the partial block and zeroes outputs
        clr_counts();
        burst(0, 16'h2000, 100);
        reset = 1'b0;
        #1;
        chk("t6_ave0", ave(0), 32'h0);
        chk("t6_scaled0", scl(0), 32'h0);
        chk("t6_ave1", ave(1), 32'h0);
        chk("t6_scaled1", scl(1), 32'h0);
        chk("t6_out_valid", 32'(out_valid), 32'h0);
        tick();
        reset = 1'b1;
        clr_counts();
        burst(0, 16'h2000, 255);
        drain(6);
        chk("t6_no_early_pulse", 32'(ov_count[0]), 32'd0);
        burst(0, 16'h2000, 1);
        drain(6);
        chk("t6_ch0_pulses", 32'(ov_count[0]), 32'd1);
        chk("t6_ave0_new", ave(0), 32'h0200);
        chk("t6_scaled0_new", scl(0), 32'd303);

        // Pass-through latency: single ch2 sample
        do_reset();
        avg_sel = 1'b0;
        set_sample(2, 16'h8000);
        tick();                              // E0
        sample_valid = '0;
        tick();                              // E1
        chk("t3_ov_e1", 32'(out_valid), 32'h0);
        tick();                              // E2
        chk("t3_ov_e2", 32'(out_valid), 32'h0);
        tick();                              // E3
        chk("t3_ov_e3", 32'(out_valid), 32'b100);
        chk("t3_ave2", ave(2), 32'h0800);
        chk("t3_scaled2", scl(2), 32'd1214);
        tick();
        chk("t3_ov_e4", 32'(out_valid), 32'h0);

        // All three channels at once: consecutive outputs in round-robin order
        do_reset();
        set_sample(0, 16'h1000);
        set_sample(1, 16'h2000);
        set_sample(2, 16'h3000);
        tick();                              // E0
        sample_valid = '0;
        drain(3);                            // E1..E3
        chk("t4_ov_c0", 32'(out_valid), 32'b001);
        tick();
        chk("t4_ov_c1", 32'(out_valid), 32'b010);
        tick();
        chk("t4_ov_c2", 32'(out_valid), 32'b100);
        chk("t4_overrun", 32'(overrun), 32'h0);
        chk("t4_ave0", ave(0), 32'h0100);
        chk("t4_ave1", ave(1), 32'h0200);
        chk("t4_ave2", ave(2), 32'h0300);
        chk("t4_scaled1", scl(1), 32'd303);
        chk("t4_scaled2", scl(2), 32'd455);

        // Overrun: second ch2 sample arrives while the first is still pending
        do_reset();
        clr_counts();
        set_sample(0, 16'h1000);
        set_sample(1, 16'h2000);
        set_sample(2, 16'h3000);
        tick();                              // E0
        sample_valid = '0;
        set_sample(2, 16'h7000);
        tick();                              // E1, ch0 granted, ch2 sample dropped
        sample_valid = '0;
        chk("t5_overrun_set", 32'(overrun), 32'b100);
        drain(6);
        chk("t5_ch2_pulses", 32'(ov_count[2]), 32'd1);
        chk("t5_ave2_first", ave(2), 32'h0300);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t5_overrun_clr", 32'(overrun), 32'h0);
        chk("t5_ave2_kept", ave(2), 32'h0300);

        // A sample coinciding with clear is dropped silently
        clr_counts();
        clear = 1'b1;
        set_sample(0, 16'h4000);
        tick();
        clear        = 1'b0;
        sample_valid = '0;
        drain(6);
        chk("t5_clear_drop_pulses", 32'(ov_count[0]), 32'd0);
        chk("t5_clear_drop_overrun", 32'(overrun), 32'h0);
        chk("t5_clear_ave0_kept", ave(0), 32'h0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
